// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM states and default byte width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO: head visible combinationally on rd_dat; write and pop commit on the clock edge.
// Latency: a byte written at edge N is visible at the head after edge N.
// Backpressure: wr_rdy = !full; writes while full are dropped, pops while empty are ignored.
module uart_txq_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i_tx,
  input  logic                  rsnt_i_tx,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  wr_rdy,
  input  logic                  rd_en,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = wr_vld && !full;
  assign pop   = rd_en && !empty;

  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign level  = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i_tx) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk_i_tx or negedge rsnt_i_tx) begin
    if (!rsnt_i_tx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Queue and launcher in front of the UART transmitter; optional stats counter under UART_TXQ_STATS_EN.
// Latency: byte accepted at edge N on an idle queue -> tx_start_o high after edge N+1.
// Backpressure: s_ready_o = !full; one byte in flight, next launch only after tx_done_i (+GAP_CYCLES).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk_i_tx,
  input  logic                  rsnt_i_tx,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_active_i,
  input  logic                  tx_done_i,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  busy_o,
  output logic [15:0]           sent_cnt_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  txq_state_e            state;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  fifo_rd_vld;
  logic [DATA_WIDTH-1:0] fifo_rd_dat;
  logic                  launch;

  assign launch = (state == ST_IDLE) && fifo_rd_vld && !tx_active_i;

  uart_txq_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk_i_tx  (clk_i_tx),
    .rsnt_i_tx (rsnt_i_tx),
    .wr_vld    (s_valid_i),
    .wr_dat    (s_data_i),
    .wr_rdy    (s_ready_o),
    .rd_en     (launch),
    .rd_vld    (fifo_rd_vld),
    .rd_dat    (fifo_rd_dat),
    .level     (level_o)
  );

  always_ff @(posedge clk_i_tx or negedge rsnt_i_tx) begin
    if (!rsnt_i_tx) begin
      state      <= ST_IDLE;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            tx_data_o  <= fifo_rd_dat;
            tx_start_o <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done_i) begin
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE) || fifo_rd_vld;

`ifdef UART_TXQ_STATS_EN
  logic [15:0] sent_cnt;

  // Only completions of a launched byte count; stray done pulses are ignored.
  always_ff @(posedge clk_i_tx or negedge rsnt_i_tx) begin
    if (!rsnt_i_tx) begin
      sent_cnt <= '0;
    end else if ((state == ST_WAIT) && tx_done_i) begin
      sent_cnt <= sent_cnt + 16'd1;
    end
  end

  assign sent_cnt_o = sent_cnt;
`else
  assign sent_cnt_o = '0;
`endif

endmodule
